div_req_sequencer: RTL and testbench

- Upstream feeder for the iterative divider. It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- It issues one division at a time to the divider with a single-cycle start pulse, then waits for the divider's one-cycle done pulse.
- It captures quotient/remainder into a one-entry result register with valid/ready.
- Divide-by-zero is handled locally without touching the divider; a watchdog recovers from a divider that never answers.

---
 rtl/div_req_sequencer_pkg.sv | 24 ++
 rtl/div_req_fifo.sv | 54 +++++
 rtl/div_req_sequencer.sv | 163 ++++++++++++++++
 tb/tb_div_req_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_req_sequencer_pkg.sv
// Shared types and constants for the divider request sequencer: FSM states,
// result flags and the quotient reported on divide-by-zero.
package div_req_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic dbz;
        logic timeout;
    } res_flags_t;

    localparam res_flags_t FLAGS_OK      = '{dbz: 1'b0, timeout: 1'b0};
    localparam res_flags_t FLAGS_DBZ     = '{dbz: 1'b1, timeout: 1'b0};
    localparam res_flags_t FLAGS_TIMEOUT = '{dbz: 1'b0, timeout: 1'b1};

    // Wide all-ones source; users take the low WIDTH bits as the DBZ quotient.
    localparam int                   MAX_WIDTH    = 64;
    localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_req_fifo.sv
// Parameterised synchronous FIFO with occupancy output; pushes when full and
// pops when empty are ignored.
module div_req_fifo #(
    parameter  int DATA_W = 20,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage has no reset; the level counter alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/div_req_sequencer.sv
// Feeds buffered operand pairs to an iterative divider one at a time, handles
// divide-by-zero locally and aborts a divider that never answers.
module div_req_sequencer
    import div_req_sequencer_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int TAG_W   = 4,
    parameter  int DEPTH   = 4,
    parameter  int TIMEOUT = 64,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_dividend,
    input  logic [WIDTH-1:0]  s_divisor,
    input  logic [TAG_W-1:0]  s_tag,
    output logic [WIDTH-1:0]  div_dividend,
    output logic [WIDTH-1:0]  div_divider,
    output logic              div_wr_valid,
    input  logic [WIDTH-1:0]  div_quotient,
    input  logic [WIDTH-1:0]  div_remainder,
    input  logic              div_rd_valid,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_quotient,
    output logic [WIDTH-1:0]  m_remainder,
    output logic [TAG_W-1:0]  m_tag,
    output logic              m_dbz,
    output logic              m_timeout,
    output logic              busy,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int REQ_W = 2 * WIDTH + TAG_W;
    localparam int WD_W  = $clog2(TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [REQ_W-1:0]  head;
    logic [WIDTH-1:0]  head_dividend;
    logic [WIDTH-1:0]  head_divisor;
    logic [TAG_W-1:0]  head_tag;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              head_ok;
    logic              load_op;
    logic              load_dbz;
    logic              rsp_ok;
    logic              rsp_to;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_expired;
    logic [TAG_W-1:0]  op_tag;
    res_flags_t        m_flags;

    div_req_fifo #(
        .DATA_W (REQ_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s_valid),
        .push_data ({s_dividend, s_divisor, s_tag}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign s_ready = !fifo_full;
    assign {head_dividend, head_divisor, head_tag} = head;

    // The head may only leave the FIFO when its result has somewhere to go.
    assign head_ok    = !fifo_empty && (!m_valid || m_ready);
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_IDLE:  if (head_ok && head_divisor != '0) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (div_rd_valid || wd_expired)    state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        div_wr_valid = (state == ST_ISSUE);
        busy         = (state != ST_IDLE);
        fifo_pop     = (state == ST_IDLE) && head_ok;
        load_op      = fifo_pop && (head_divisor != '0);
        load_dbz     = fifo_pop && (head_divisor == '0);
        rsp_ok       = (state == ST_WAIT) && div_rd_valid;
        rsp_to       = (state == ST_WAIT) && !div_rd_valid && wd_expired;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT && !div_rd_valid && !wd_expired) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Operands stay frozen from ISSUE through WAIT; they change only on the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_dividend <= '0;
            div_divider  <= '0;
            op_tag       <= '0;
        end else if (load_op) begin
            div_dividend <= head_dividend;
            div_divider  <= head_divisor;
            op_tag       <= head_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid     <= 1'b0;
            m_quotient  <= '0;
            m_remainder <= '0;
            m_tag       <= '0;
            m_flags     <= FLAGS_OK;
        end else if (rsp_ok) begin
            m_valid     <= 1'b1;
            m_quotient  <= div_quotient;
            m_remainder <= div_remainder;
            m_tag       <= op_tag;
            m_flags     <= FLAGS_OK;
        end else if (rsp_to) begin
            m_valid     <= 1'b1;
            m_quotient  <= '0;
            m_remainder <= '0;
            m_tag       <= op_tag;
            m_flags     <= FLAGS_TIMEOUT;
        end else if (load_dbz) begin
            m_valid     <= 1'b1;
            m_quotient  <= DBZ_QUOTIENT[WIDTH-1:0];
            m_remainder <= head_dividend;
            m_tag       <= head_tag;
            m_flags     <= FLAGS_DBZ;
        end else if (m_valid && m_ready) begin
            m_valid     <= 1'b0;
        end
    end

    assign m_dbz     = m_flags.dbz;
    assign m_timeout = m_flags.timeout;

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed bench for div_req_sequencer with a fixed-latency behavioural divider.
module tb_div_req_sequencer;

    localparam int WIDTH   = 8;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;
    localparam int DIV_LAT = 10;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_dividend;
    logic [WIDTH-1:0] s_divisor;
    logic [TAG_W-1:0] s_tag;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divider;
    logic             div_wr_valid;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             div_rd_valid;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_quotient;
    logic [WIDTH-1:0] m_remainder;
    logic [TAG_W-1:0] m_tag;
    logic             m_dbz;
    logic             m_timeout;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;

    logic model_rd;
    logic inj_rd;
    bit   div_en;
    int   wr_count;
    int   tests;
    int   errors;

    assign div_rd_valid = model_rd | inj_rd;

    always #5 clk = ~clk;

    div_req_sequencer #(
        .WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_dividend(s_dividend), .s_divisor(s_divisor), .s_tag(s_tag),
        .div_dividend(div_dividend), .div_divider(div_divider),
        .div_wr_valid(div_wr_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_rd_valid(div_rd_valid),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_quotient(m_quotient), .m_remainder(m_remainder), .m_tag(m_tag),
        .m_dbz(m_dbz), .m_timeout(m_timeout),
        .busy(busy), .fifo_level(fifo_level)
    );

    // Behavioural divider: answers DIV_LAT cycles after a start pulse when enabled.
    initial begin
        int               cnt;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        cnt = 0; a = '0; b = '1;
        model_rd = 1'b0; div_quotient = '0; div_remainder = '0;
        forever begin
            @(posedge clk); #1;
            model_rd = 1'b0;
            if (div_wr_valid) wr_count++;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_rd      = 1'b1;
                    div_quotient  = a / b;
                    div_remainder = a % b;
                end
            end else if (div_wr_valid && div_en) begin
                cnt = DIV_LAT;
                a   = div_dividend;
                b   = div_divider;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_req(input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv,
                            input logic [TAG_W-1:0] tg);
        int   n;
        logic rdy;
        n = 0;
        s_valid = 1'b1; s_dividend = dd; s_divisor = dv; s_tag = tg;
        do begin
            rdy = s_ready;
            step(1);
            n++;
        end while (!rdy && n < 200);
        s_valid = 1'b0;
        if (!rdy) begin
            tests++; errors++;
            $display("FAIL push_accept: s_ready never seen for tag %0d", tg);
        end
    endtask

    task automatic wait_valid(input string name, input int limit, output int cycles);
        cycles = 0;
        while (!m_valid && cycles < limit) begin
            step(1);
            cycles++;
        end
        tests++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait: m_valid=%b after %0d cycles, want 1", name, m_valid, cycles);
        end
    endtask

    task automatic consume();
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({s_ready, fifo_level, busy, div_wr_valid, m_valid, m_dbz, m_timeout} !== {1'b1, 3'd0, 5'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: s_ready=%b level=%0d busy=%b wr=%b mv=%b dbz=%b to=%b, want 1 0 0 0 0 0 0",
                     s_ready, fifo_level, busy, div_wr_valid, m_valid, m_dbz, m_timeout);
        end
        tests++;
        if ({m_quotient, m_remainder, m_tag, div_dividend, div_divider} !== '0) begin
            errors++;
            $display("FAIL reset_data: q=%0d r=%0d tag=%0d dd=%0d dv=%0d, want all 0",
                     m_quotient, m_remainder, m_tag, div_dividend, div_divider);
        end
    endtask

    task automatic test_basic();
        int wr0;
        int cyc;
        wr0 = wr_count;
        push_req(8'd100, 8'd7, 4'd3);
        wait_valid("basic", 60, cyc);
        tests++;
        if ({m_quotient, m_remainder, m_tag, m_dbz, m_timeout} !== {8'd14, 8'd2, 4'd3, 2'b00}) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d tag=%0d dbz=%b to=%b, want 14 2 3 0 0",
                     m_quotient, m_remainder, m_tag, m_dbz, m_timeout);
        end
        tests++;
        if (wr_count - wr0 !== 1) begin
            errors++;
            $display("FAIL basic_start_pulses: got %0d, want 1", wr_count - wr0);
        end
        consume();
    endtask

    task automatic test_dbz();
        int wr0;
        wr0 = wr_count;
        push_req(8'd55, 8'd0, 4'd1);
        tests++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL dbz_early: m_valid=%b while request only at head, want 0", m_valid);
        end
        step(1);
        tests++;
        if ({m_valid, m_quotient, m_remainder, m_tag, m_dbz, m_timeout} !== {1'b1, 8'd255, 8'd55, 4'd1, 2'b10}) begin
            errors++;
            $display("FAIL dbz_result: mv=%b q=%0d r=%0d tag=%0d dbz=%b to=%b, want 1 255 55 1 1 0",
                     m_valid, m_quotient, m_remainder, m_tag, m_dbz, m_timeout);
        end
        tests++;
        if (wr_count !== wr0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dbz_no_start: pulses=%0d busy=%b, want 0 0", wr_count - wr0, busy);
        end
        consume();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] dd [5] = '{8'd20, 8'd17, 8'd9, 8'd250, 8'd7};
        logic [WIDTH-1:0] dv [5] = '{8'd3, 8'd4, 8'd0, 8'd16, 8'd9};
        logic [WIDTH-1:0] eq [5] = '{8'd6, 8'd4, 8'd255, 8'd15, 8'd0};
        logic [WIDTH-1:0] er [5] = '{8'd2, 8'd1, 8'd9, 8'd10, 8'd7};
        logic             ez [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int               cyc;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_req(dd[i], dv[i], TAG_W'(5 + i));
        tests++;
        if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: level=%0d s_ready=%b, want 4 0", fifo_level, s_ready);
        end
        wait_valid("bp_first", 60, cyc);
        step(3);
        tests++;
        if (fifo_level !== 3'd4 || s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: level=%0d s_ready=%b busy=%b, want 4 0 0", fifo_level, s_ready, busy);
        end
        for (int i = 0; i < 5; i++) begin
            wait_valid("bp_drain", 60, cyc);
            tests++;
            if ({m_quotient, m_remainder, m_tag, m_dbz} !== {eq[i], er[i], TAG_W'(5 + i), ez[i]}) begin
                errors++;
                $display("FAIL bp_result[%0d]: q=%0d r=%0d tag=%0d dbz=%b, want %0d %0d %0d %b",
                         i, m_quotient, m_remainder, m_tag, m_dbz, eq[i], er[i], 5 + i, ez[i]);
            end
            consume();
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int n;
        div_en = 1'b0;
        push_req(8'd9, 8'd3, 4'd2);
        n = 0;
        while (!(busy && !div_wr_valid) && n < 10) begin step(1); n++; end
        wait_valid("timeout", 100, cyc);
        tests++;
        if (cyc !== TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: m_valid after %0d cycles in WAIT, want %0d", cyc, TIMEOUT);
        end
        tests++;
        if ({m_quotient, m_remainder, m_tag, m_dbz, m_timeout} !== {8'd0, 8'd0, 4'd2, 2'b01}) begin
            errors++;
            $display("FAIL timeout_result: q=%0d r=%0d tag=%0d dbz=%b to=%b, want 0 0 2 0 1",
                     m_quotient, m_remainder, m_tag, m_dbz, m_timeout);
        end
        consume();
        div_en = 1'b1;
        push_req(8'd9, 8'd3, 4'd4);
        wait_valid("after_timeout", 60, cyc);
        tests++;
        if ({m_quotient, m_remainder, m_tag, m_dbz, m_timeout} !== {8'd3, 8'd0, 4'd4, 2'b00}) begin
            errors++;
            $display("FAIL after_timeout_result: q=%0d r=%0d tag=%0d dbz=%b to=%b, want 3 0 4 0 0",
                     m_quotient, m_remainder, m_tag, m_dbz, m_timeout);
        end
        consume();
    endtask

    task automatic test_spurious_and_reset();
        int seen;
        int n;
        inj_rd = 1'b1;
        step(1);
        inj_rd = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_valid || busy) seen++;
            step(1);
        end
        tests++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL spurious_idle: m_valid/busy seen %0d cycles, want 0", seen);
        end
        push_req(8'd100, 8'd7, 4'd1);
        n = 0;
        while (!(busy && !div_wr_valid) && n < 10) begin step(1); n++; end
        push_req(8'd50, 8'd5, 4'd2);
        push_req(8'd60, 8'd6, 4'd3);
        step(1);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({m_valid, busy, div_wr_valid, s_ready, fifo_level, m_quotient, div_dividend, div_divider}
                !== {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_midwait: mv=%b busy=%b wr=%b s_ready=%b level=%0d q=%0d dd=%0d dv=%0d, want 0 0 0 1 0 0 0 0",
                     m_valid, busy, div_wr_valid, s_ready, fifo_level, m_quotient, div_dividend, div_divider);
        end
        step(1);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (m_valid || busy) seen++;
            step(1);
        end
        tests++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL late_rd_after_reset: m_valid/busy seen %0d cycles, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] q [2];
        logic [WIDTH-1:0] r [2];
        logic [TAG_W-1:0] t [2];
        logic             z [2];
        int               nres;
        nres = 0;
        m_ready = 1'b1;
        push_req(8'd200, 8'd10, 4'd10);
        push_req(8'd200, 8'd0, 4'd11);
        for (int i = 0; i < 60; i++) begin
            if (m_valid) begin
                if (nres < 2) begin
                    q[nres] = m_quotient; r[nres] = m_remainder; t[nres] = m_tag; z[nres] = m_dbz;
                end
                nres++;
            end
            step(1);
        end
        m_ready = 1'b0;
        tests++;
        if (nres !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 2", nres);
        end else begin
            tests++;
            if ({q[0], r[0], t[0], z[0]} !== {8'd20, 8'd0, 4'd10, 1'b0}) begin
                errors++;
                $display("FAIL b2b_first: q=%0d r=%0d tag=%0d dbz=%b, want 20 0 10 0", q[0], r[0], t[0], z[0]);
            end
            tests++;
            if ({q[1], r[1], t[1], z[1]} !== {8'd255, 8'd200, 4'd11, 1'b1}) begin
                errors++;
                $display("FAIL b2b_second: q=%0d r=%0d tag=%0d dbz=%b, want 255 200 11 1", q[1], r[1], t[1], z[1]);
            end
        end
    endtask

    initial begin
        tests = 0; errors = 0; wr_count = 0;
        div_en = 1'b1; inj_rd = 1'b0;
        s_valid = 1'b0; s_dividend = '0; s_divisor = '0; s_tag = '0;
        m_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        test_reset();
        test_basic();
        test_dbz();
        test_backpressure();
        test_timeout();
        test_spurious_and_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
